// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters, one op in flight, with a WAIT watchdog.
// Optional statistics (grant/timeout counters, STAT_SEL/STAT_DATA) are enabled by defining ALU_SCHED_STATS_EN.
module alu_op_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [NUM_REQ-1:0]            req_vld_i,
   input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
   output logic [NUM_REQ-1:0]            req_rdy_o,
   input  logic                          alu_rdy_i,
   output logic                          alu_act_o,
   output logic [OP_WIDTH-1:0]           alu_op_o,
   output logic [DATA_WIDTH-1:0]         alu_a_o,
   output logic [DATA_WIDTH-1:0]         alu_b_o,
   input  logic [DATA_WIDTH-1:0]         ex_alu_i,
   input  logic                          ex_alu_vld_i,
   output logic [NUM_REQ-1:0]            rsp_vld_o,
   output logic [DATA_WIDTH-1:0]         rsp_data_o,
   output logic                          rsp_err_o,
`ifdef ALU_SCHED_STATS_EN
   input  logic [3:0]                    stat_sel_i,
   output logic [15:0]                   stat_data_o,
`endif
   output logic                          busy_o
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t                  state_q;
   logic [IW-1:0]           rr_ptr_q;
   logic [IW-1:0]           owner_q;
   logic [7:0]              cnt_q;
   logic                    alu_act_q;
   logic [OP_WIDTH-1:0]     alu_op_q;
   logic [DATA_WIDTH-1:0]   alu_a_q;
   logic [DATA_WIDTH-1:0]   alu_b_q;
   logic [NUM_REQ-1:0]      rsp_vld_q;
   logic [DATA_WIDTH-1:0]   rsp_data_q;
   logic                    rsp_err_q;
   logic                    busy_q;

   logic [IW-1:0]           win_d;
   logic [IW-1:0]           idx;
   logic                    found;
   logic                    gnt_vld;
   logic                    timeout_hit;

   // Descending scan: the smallest offset from rr_ptr is assigned last and therefore wins.
   always_comb begin
      win_d = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (req_vld_i[idx]) begin
            win_d = idx;
            found = 1'b1;
         end
      end
   end

   assign gnt_vld     = (state_q == S_IDLE) && alu_rdy_i && found;
   assign timeout_hit = (state_q == S_WAIT) && !ex_alu_vld_i && (cnt_q == 8'(TIMEOUT - 1));
   // Grant is masked during reset so no handshake can complete while the FSM is held.
   assign req_rdy_o   = (gnt_vld && rst_n_i) ? (NUM_REQ'(1) << win_d) : '0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         alu_act_q  <= 1'b0;
         alu_op_q   <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_vld) begin
                  owner_q   <= win_d;
                  alu_op_q  <= req_op_i[win_d*OP_WIDTH +: OP_WIDTH];
                  alu_a_q   <= req_a_i[win_d*DATA_WIDTH +: DATA_WIDTH];
                  alu_b_q   <= req_b_i[win_d*DATA_WIDTH +: DATA_WIDTH];
                  alu_act_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               alu_act_q <= 1'b0;
               cnt_q     <= '0;
               if (ex_alu_vld_i) begin
                  rsp_vld_q  <= NUM_REQ'(1) << owner_q;
                  rsp_data_q <= ex_alu_i;
                  rsp_err_q  <= 1'b0;
                  state_q    <= S_RESP;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               if (ex_alu_vld_i) begin
                  rsp_vld_q  <= NUM_REQ'(1) << owner_q;
                  rsp_data_q <= ex_alu_i;
                  rsp_err_q  <= 1'b0;
                  state_q    <= S_RESP;
               end else if (timeout_hit) begin
                  rsp_vld_q  <= NUM_REQ'(1) << owner_q;
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= S_RESP;
               end
            end
            default: begin
               rsp_vld_q  <= '0;
               rsp_data_q <= '0;
               rsp_err_q  <= 1'b0;
               busy_q     <= 1'b0;
               rr_ptr_q   <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_act_o  = alu_act_q;
   assign alu_op_o   = alu_op_q;
   assign alu_a_o    = alu_a_q;
   assign alu_b_o    = alu_b_q;
   assign rsp_vld_o  = rsp_vld_q;
   assign rsp_data_o = rsp_data_q;
   assign rsp_err_o  = rsp_err_q;
   assign busy_o     = busy_q;

`ifdef ALU_SCHED_STATS_EN
   logic [15:0] grant_cnt_q [NUM_REQ];
   logic [15:0] to_cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
         to_cnt_q <= '0;
      end else begin
         if (gnt_vld && grant_cnt_q[win_d] != 16'hFFFF) grant_cnt_q[win_d] <= grant_cnt_q[win_d] + 16'd1;
         if (timeout_hit && to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
      end
   end

   always_comb begin
      stat_data_o = '0;
      if (stat_sel_i == 4'hF) stat_data_o = to_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_sel_i == 4'(i)) stat_data_o = grant_cnt_q[i];
      end
   end
`endif
endmodule

// File: tb/tb_alu_op_scheduler.sv
// Randomized self-checking bench for alu_op_scheduler against a transaction-level round-robin/latency model.
module tb_alu_op_scheduler;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int OW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_vld = '0;
   logic [N*OW-1:0] req_op = '0;
   logic [N*DW-1:0] req_a = '0, req_b = '0;
   logic [N-1:0]  req_rdy;
   logic          alu_rdy = 1'b0;
   logic          alu_act;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_a, alu_b;
   logic [DW-1:0] ex_alu = '0;
   logic          ex_alu_vld = 1'b0;
   logic [N-1:0]  rsp_vld;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          busy;
`ifdef ALU_SCHED_STATS_EN
   logic [3:0]    stat_sel = '0;
   logic [15:0]   stat_data;
`endif

   int checks = 0;
   int errors = 0;
   int rr = 0;

   always #5 clk = ~clk;

   alu_op_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_vld_i(req_vld), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
      .req_rdy_o(req_rdy), .alu_rdy_i(alu_rdy),
      .alu_act_o(alu_act), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .ex_alu_i(ex_alu), .ex_alu_vld_i(ex_alu_vld),
      .rsp_vld_o(rsp_vld), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
`ifdef ALU_SCHED_STATS_EN
      .stat_sel_i(stat_sel), .stat_data_o(stat_data),
`endif
      .busy_o(busy)
   );

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
      return -1;
   endfunction

   // lat: cycles after ISSUE at which the ALU answers (0 = in ISSUE); -1 = never answers.
   task automatic do_op(input logic [N-1:0] v, input logic [N*OW-1:0] ops,
                        input logic [N*DW-1:0] as, input logic [N*DW-1:0] bs,
                        input int lat, input logic [DW-1:0] res);
      int w, rc;
      bit err;
      logic [OW-1:0] e_op;
      logic [DW-1:0] e_a, e_b, e_d;
      w   = pick(v);
      err = !(lat >= 0 && lat <= TO);
      rc  = err ? TO + 2 : lat + 2;
      e_op = ops[w*OW +: OW];
      e_a  = as[w*DW +: DW];
      e_b  = bs[w*DW +: DW];
      e_d  = err ? '0 : res;
      @(negedge clk);
      req_vld = v; req_op = ops; req_a = as; req_b = bs; alu_rdy = 1'b1;
      ex_alu_vld = 1'b0; ex_alu = DW'($urandom);
      #1;
      checks++;
      if (req_rdy !== N'(1 << w) || busy !== 1'b0) begin
         errors++;
         $display("FAIL grant: req_rdy=%b busy=%b required req_rdy=%b busy=0", req_rdy, busy, N'(1 << w));
      end
      for (int c = 1; c <= rc; c++) begin
         @(negedge clk);
         req_vld = N'($urandom);
         ex_alu_vld = (c == rc) ? 1'($urandom) : (!err && c - 1 == lat);
         ex_alu = (!err && c - 1 == lat) ? res : DW'($urandom);
         #1;
         if (c == 1) begin
            checks++;
            if (alu_act !== 1'b1 || alu_op !== e_op || alu_a !== e_a || alu_b !== e_b) begin
               errors++;
               $display("FAIL issue: act=%b op=%h a=%h b=%h required 1 %h %h %h", alu_act, alu_op, alu_a, alu_b, e_op, e_a, e_b);
            end
         end
         if (c < rc) begin
            checks++;
            if (rsp_vld !== '0 || req_rdy !== '0 || busy !== 1'b1 || (c > 1 && alu_act !== 1'b0)) begin
               errors++;
               $display("FAIL inflight c=%0d: rsp_vld=%b req_rdy=%b busy=%b act=%b required 0 0 1", c, rsp_vld, req_rdy, busy, alu_act);
            end
         end else begin
            checks++;
            if (rsp_vld !== N'(1 << w) || rsp_data !== e_d || rsp_err !== err || busy !== 1'b1 ||
                alu_act !== 1'b0 || alu_op !== e_op || alu_a !== e_a || alu_b !== e_b) begin
               errors++;
               $display("FAIL response: rsp_vld=%b data=%h err=%b op=%h required %b %h %b %h",
                        rsp_vld, rsp_data, rsp_err, alu_op, N'(1 << w), e_d, err, e_op);
            end
         end
      end
      rr = (w + 1) % N;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_vld = '1; alu_rdy = 1'b1; ex_alu_vld = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (req_rdy !== '0 || alu_act !== 0 || alu_op !== '0 || alu_a !== '0 || alu_b !== '0 ||
          rsp_vld !== '0 || rsp_data !== '0 || rsp_err !== 0 || busy !== 0) begin
         errors++;
         $display("FAIL reset: rdy=%b act=%b op=%h a=%h b=%h rsp=%b d=%h e=%b busy=%b required all 0",
                  req_rdy, alu_act, alu_op, alu_a, alu_b, rsp_vld, rsp_data, rsp_err, busy);
      end
      @(negedge clk);
      rst_n = 1'b1; req_vld = '0; ex_alu_vld = 1'b0;
      rr = 0;
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (pick(4'hF) !== exp_seq[i]) begin
            errors++;
            $display("FAIL rr_model: got %0d required %0d", pick(4'hF), exp_seq[i]);
         end
         do_op(4'hF, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), 0, DW'($urandom));
      end
   endtask

   task automatic test_single();
      logic [N*OW-1:0] ops;
      logic [N*DW-1:0] as, bs;
      ops = '0; as = '0; bs = '0;
      ops[2*OW +: OW] = 4'h1;
      as[2*DW +: DW]  = 8'h05;
      bs[2*DW +: DW]  = 8'h03;
      do_op(4'b0100, ops, as, bs, 4, 8'h08);
   endtask

   task automatic test_timeout();
      do_op(4'b0010, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), -1, 8'h00);
      do_op(4'b1111, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), 1, DW'($urandom));
   endtask

   task automatic test_same_cycle();
      do_op(4'b1000, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), TO, 8'hAA);
      do_op(4'b0001, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), TO - 1, 8'h5C);
   endtask

   task automatic test_backpressure();
      logic [N-1:0] v;
      v = N'($urandom_range(1, 15));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_vld = N'($urandom_range(1, 15)); alu_rdy = 1'b0; ex_alu_vld = 1'($urandom);
         #1;
         checks++;
         if (req_rdy !== '0 || busy !== 1'b0 || rsp_vld !== '0) begin
            errors++;
            $display("FAIL backpressure: req_rdy=%b busy=%b rsp=%b required 0 0 0", req_rdy, busy, rsp_vld);
         end
      end
      do_op(v, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), 2, DW'($urandom));
   endtask

   task automatic test_random();
      int lat;
      for (int i = 0; i < 25; i++) begin
         lat = int'($urandom_range(0, TO + 3)) - 1;
         do_op(N'($urandom_range(1, 15)), N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), lat, DW'($urandom));
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_vld = 4'b1000; alu_rdy = 1'b1; ex_alu_vld = 1'b0; req_op = '1; req_a = '1; req_b = '1;
      #1;
      checks++;
      if (req_rdy !== 4'b1000) begin
         errors++;
         $display("FAIL mid_grant: req_rdy=%b required 1000", req_rdy);
      end
      repeat (4) @(negedge clk);
      req_vld = 4'hF;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (req_rdy !== '0 || alu_act !== 0 || alu_op !== '0 || alu_a !== '0 || alu_b !== '0 ||
          rsp_vld !== '0 || rsp_data !== '0 || rsp_err !== 0 || busy !== 0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b act=%b op=%h a=%h rsp=%b busy=%b required all 0",
                  req_rdy, alu_act, alu_op, alu_a, rsp_vld, busy);
      end
      @(negedge clk);
      rst_n = 1'b1; req_vld = '0; rr = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ex_alu_vld = 1'b1; ex_alu = 8'h77;
         #1;
         checks++;
         if (rsp_vld !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_result: rsp_vld=%b busy=%b required 0 0", rsp_vld, busy);
         end
      end
      do_op(4'hF, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), 0, DW'($urandom));
   endtask

`ifdef ALU_SCHED_STATS_EN
   task automatic test_stats();
      logic [15:0] exp_v [4] = '{16'd5, 16'd1, 16'd0, 16'd0};
      logic [3:0]  sel_v [4] = '{4'd1, 4'd15, 4'd0, 4'd14};
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; rr = 0;
      for (int i = 0; i < 4; i++)
         do_op(4'b0010, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), 0, DW'($urandom));
      do_op(4'b0010, N*OW'($urandom), N*DW'($urandom), N*DW'($urandom), -1, 8'h00);
      for (int i = 0; i < 4; i++) begin
         stat_sel = sel_v[i];
         #1;
         checks++;
         if (stat_data !== exp_v[i]) begin
            errors++;
            $display("FAIL stat sel=%0d: got %0d required %0d", sel_v[i], stat_data, exp_v[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_timeout();
      test_same_cycle();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef ALU_SCHED_STATS_EN
      test_stats();
`endif
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Shares one ALU between `NUM_REQ` requesters under round-robin arbitration, with one operation outstanding at a time. It issues the granted operation to the ALU and routes the result back to the owning requester. A watchdog ends any operation the ALU never answers. It sits between the requester ports (stimulus drivers or CPU-side clients) and the ALU DUT's `ACT`/`OP`/`REG_A`/`REG_B` inputs and its `EX_ALU`/`EX_ALU_VLD` outputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_WIDTH`, 8: operand and result width
- `OP_WIDTH`, 4: ALU opcode width
- `TIMEOUT`, 16: WAIT cycles before error response, 2..255
- `CLK` in 1: single clock; all logic is rising-edge
- `RST_N` in 1: asynchronous active-low reset
- `REQ_VLD` in NUM_REQ: per-requester operation valid
- `REQ_OP` in NUM_REQ*OP_WIDTH: opcodes, requester i at slice i
- `REQ_A`, `REQ_B` in NUM_REQ*DATA_WIDTH: operands, packed the same way
- `REQ_RDY` out NUM_REQ: one-hot grant; handshake completes when `REQ_VLD[i] & REQ_RDY[i]`
- `ALU_RDY` in 1: ALU can accept an operation
- `ALU_ACT` out 1: issue strobe, one cycle
- `ALU_OP` out OP_WIDTH: registered opcode
- `ALU_A`, `ALU_B` out DATA_WIDTH: registered operands
- `EX_ALU` in DATA_WIDTH: ALU result
- `EX_ALU_VLD` in 1: result valid
- `RSP_VLD` out NUM_REQ: one-hot response pulse, one cycle, no backpressure
- `RSP_DATA` out DATA_WIDTH: response result
- `RSP_ERR` out 1: response is a timeout
- `BUSY` out 1: state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If `ALU_RDY=1` and any `REQ_VLD`, the winner is the first set bit at or after `rr_ptr`, searching upward and wrapping mod `NUM_REQ`.
  - `REQ_RDY[winner]=1` combinationally in the same cycle.
  - The winner's op and operands are captured, the winner index is stored, and the FSM moves to ISSUE.
  - `REQ_RDY` is all-zero in every other state, and whenever `ALU_RDY=0`.
- **ISSUE**
  - `ALU_ACT=1` with the captured op and operands.
  - The timeout counter clears to 0.
  - If `EX_ALU_VLD=1` this cycle, go to RESP; otherwise go to WAIT.
- **WAIT**
  - The counter increments each cycle.
  - If `EX_ALU_VLD=1`, capture `EX_ALU` and go to RESP.
  - Otherwise, if counter == `TIMEOUT-1`, go to RESP with the error flag set.
  - If the result arrives on the same cycle as the timeout, the result wins and there is no error.
- **RESP**
  - `RSP_VLD[owner]=1` for one cycle.
  - `RSP_DATA` holds the result, or 0 on error; `RSP_ERR` equals the error flag.
  - `rr_ptr` becomes `(owner+1) mod NUM_REQ`.
  - Next state is IDLE.
- Outside RESP, `RSP_VLD`, `RSP_DATA` and `RSP_ERR` are 0.
- `EX_ALU_VLD` in IDLE or RESP is ignored.
- An `EX_ALU` wider than `DATA_WIDTH` is not supported; widths must match.
- The ALU output registers (`ALU_OP`, `ALU_A`, `ALU_B`) hold their last values between issues.
- Reset values: state IDLE, `rr_ptr=0`, counter 0.
  - All outputs are 0: `REQ_RDY`, `ALU_ACT`, `ALU_OP`, `ALU_A`, `ALU_B`, `RSP_VLD`, `RSP_DATA`, `RSP_ERR`, `BUSY`.
- Reset mid-operation abandons the operation with no response. A late `EX_ALU_VLD` is then ignored, because the FSM is in IDLE.

## Timing
- Grant at cycle T; `ALU_ACT` at T+1.
- Result sampled at cycle R (R ≥ T+1); `RSP_VLD` at R+1.
- Minimum grant-to-response latency is 2 cycles: result sampled in ISSUE.
- Timeout response at T+2+`TIMEOUT`.
- Back-to-back throughput: the next grant is possible in the IDLE cycle right after RESP, so the minimum issue-to-issue interval is 3 cycles.
- `rr_ptr` updates only in RESP, so a requester held off by `ALU_RDY=0` keeps its priority.

## Configuration
- `ALU_SCHED_STATS_EN` defined adds statistics:
  - Per-requester 16-bit saturating grant counters and a 16-bit saturating timeout counter, all cleared by reset.
  - Extra ports: `STAT_SEL` in 4 and `STAT_DATA` out 16.
  - `STAT_SEL` = i < `NUM_REQ` returns grant count i, `STAT_SEL` = 15 returns the timeout count, and any other value returns 0.
  - `STAT_DATA` is combinational from the counters.
- Undefined: the counters and both ports are absent, and the rest of the behaviour is identical.

## Test plan
- Round-robin fairness: `NUM_REQ=4`, all `REQ_VLD=1`, ALU answers in 1 cycle.
  - Grants go 0,1,2,3,0; responses arrive 2 cycles after each grant; issues are 3 cycles apart.
- Single requester: only `REQ_VLD[2]` set, op ADD, A=0x05, B=0x03, ALU returns 0x08 after 4 WAIT cycles.
  - `RSP_VLD=4'b0100`, `RSP_DATA=0x08`, `RSP_ERR=0`.
- Timeout: `TIMEOUT=16`, `EX_ALU_VLD` never asserted.
  - `RSP_VLD` appears at T+18 with `RSP_ERR=1` and `RSP_DATA=0`; the next grant follows.
- Same-cycle result and timeout: `EX_ALU_VLD` in the 16th WAIT cycle with value 0xAA.
  - `RSP_DATA=0xAA`, `RSP_ERR=0`.
- Backpressure and reset:
  - `ALU_RDY=0` for 10 cycles: no `REQ_RDY`, and the pointer is unchanged.
  - `RST_N` asserted in WAIT: all outputs are 0 immediately; a later `EX_ALU_VLD` produces no `RSP_VLD`.
- With `ALU_SCHED_STATS_EN`: 5 grants to requester 1 and 1 timeout.
  - `STAT_SEL=1` reads 5; `STAT_SEL=15` reads 1.
